// File: rtl/color_pkg.sv
// Shared codes and types for the colour scan controller: sensor filter/scale codes,
// colour result codes, FSM states and scan channel ordering.
package color_pkg;

    localparam logic [1:0] FILTER_RED   = 2'b00;
    localparam logic [1:0] FILTER_BLUE  = 2'b01;
    localparam logic [1:0] FILTER_GREEN = 2'b11;
    localparam logic [1:0] FILTER_CLEAR = 2'b10;

    localparam logic [2:0] COLOR_NONE  = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;
    localparam logic [2:0] COLOR_GREEN = 3'b100;

    localparam logic [1:0] SCALE_OFF     = 2'b00;
    localparam logic [1:0] DEFAULT_SCALE = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_CLASSIFY} state_t;
    typedef enum logic [1:0] {CH_RED, CH_BLUE, CH_GREEN, CH_CLEAR} channel_t;

    function automatic logic [1:0] filter_code(input channel_t ch);
        case (ch)
            CH_RED:   return FILTER_RED;
            CH_BLUE:  return FILTER_BLUE;
            CH_GREEN: return FILTER_GREEN;
            default:  return FILTER_CLEAR;
        endcase
    endfunction

    function automatic channel_t next_channel(input channel_t ch);
        case (ch)
            CH_RED:  return CH_BLUE;
            CH_BLUE: return CH_GREEN;
            default: return CH_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/edge_window_counter.sv
// Synchronises the sensor square wave, detects rising edges and counts them
// (saturating) while enabled. window_count already includes this cycle's edge.
module edge_window_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_freq,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] window_count
);

    logic [1:0]       sync_reg;
    logic             prev_reg;
    logic             edge_reg;
    logic [CNT_W-1:0] count_reg;
    logic             at_max;

    assign at_max       = &count_reg;
    assign window_count = (enable && edge_reg && !at_max) ? count_reg + CNT_W'(1) : count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            edge_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], sensor_freq};
            prev_reg <= sync_reg[1];
            edge_reg <= sync_reg[1] & ~prev_reg;
            if (clear)
                count_reg <= '0;
            else
                count_reg <= window_count;
        end
    end

endmodule

// File: rtl/color_scan_controller.sv
// Timed filter scan of a TCS3200-style sensor with settle, window counting and colour
// classification. Define COLOR_SCAN_CLEAR_EN to add the clear channel to the scan.
module color_scan_controller
    import color_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned WINDOW_CYCLES = 50000,
    parameter int unsigned CNT_W         = 16,
    parameter logic [1:0]  SCALE_SEL     = DEFAULT_SCALE,
    parameter int unsigned MIN_COUNT     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             sensor_freq,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [2:0]       color,
    output logic             result_valid,
    output logic             busy
);

    localparam int unsigned TIMER_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned TW        = $clog2(TIMER_MAX + 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);

`ifdef COLOR_SCAN_CLEAR_EN
    localparam channel_t LAST_CH = CH_CLEAR;
    logic [CNT_W-1:0] clear_shadow;
`else
    localparam channel_t LAST_CH = CH_GREEN;
`endif

    state_t           state_reg;
    channel_t         chan_reg;
    logic [TW-1:0]    timer_reg;
    logic [CNT_W-1:0] red_shadow, blue_shadow, green_shadow;
    logic [CNT_W-1:0] window_count;
    logic             timer_done;
    logic             clear_qualified;

    assign timer_done = (timer_reg == '0);

`ifdef COLOR_SCAN_CLEAR_EN
    assign clear_qualified = (clear_shadow >= MIN_CNT);
`else
    assign clear_qualified = 1'b1;
    assign clear_cnt       = '0;
`endif

    edge_window_counter #(.CNT_W(CNT_W)) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_freq  (sensor_freq),
        .clear        (state_reg == ST_SETTLE && timer_done),
        .enable       (state_reg == ST_MEASURE),
        .window_count (window_count)
    );

    // Winner must be strictly greater than both other RGB counts; ties give no colour.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] b,
                                            input logic [CNT_W-1:0] g, input logic qualified);
        logic [2:0] result;
        result = COLOR_NONE;
        if (r > b && r > g && r >= MIN_CNT)
            result = COLOR_RED;
        else if (g > r && g > b && g >= MIN_CNT)
            result = COLOR_GREEN;
        else if (b > r && b > g && b >= MIN_CNT)
            result = COLOR_BLUE;
        if (!qualified)
            result = COLOR_NONE;
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            chan_reg     <= CH_RED;
            timer_reg    <= '0;
            red_shadow   <= '0;
            blue_shadow  <= '0;
            green_shadow <= '0;
            scale        <= SCALE_OFF;
            filter       <= FILTER_RED;
            red_cnt      <= '0;
            blue_cnt     <= '0;
            green_cnt    <= '0;
            color        <= COLOR_NONE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef COLOR_SCAN_CLEAR_EN
            clear_shadow <= '0;
            clear_cnt    <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SETTLE;
                        chan_reg  <= CH_RED;
                        filter    <= FILTER_RED;
                        scale     <= SCALE_SEL;
                        timer_reg <= SETTLE_LOAD;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_done) begin
                        state_reg <= ST_MEASURE;
                        timer_reg <= WINDOW_LOAD;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (timer_done) begin
                        case (chan_reg)
                            CH_RED:   red_shadow   <= window_count;
                            CH_BLUE:  blue_shadow  <= window_count;
                            CH_GREEN: green_shadow <= window_count;
                            default: begin
`ifdef COLOR_SCAN_CLEAR_EN
                                clear_shadow <= window_count;
`endif
                            end
                        endcase
                        if (chan_reg == LAST_CH) begin
                            state_reg <= ST_CLASSIFY;
                        end else begin
                            // Filter only moves on SETTLE entry, never inside a window.
                            state_reg <= ST_SETTLE;
                            chan_reg  <= next_channel(chan_reg);
                            filter    <= filter_code(next_channel(chan_reg));
                            timer_reg <= SETTLE_LOAD;
                        end
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                default: begin
                    red_cnt      <= red_shadow;
                    blue_cnt     <= blue_shadow;
                    green_cnt    <= green_shadow;
`ifdef COLOR_SCAN_CLEAR_EN
                    clear_cnt    <= clear_shadow;
`endif
                    color        <= classify(red_shadow, blue_shadow, green_shadow, clear_qualified);
                    result_valid <= 1'b1;
                    chan_reg     <= CH_RED;
                    filter       <= FILTER_RED;
                    if (continuous) begin
                        state_reg <= ST_SETTLE;
                        timer_reg <= SETTLE_LOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                        scale     <= SCALE_OFF;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_scan_controller.sv
// Randomised bench for color_scan_controller: a periodic sensor model per filter and a
// scan-level reference model checked every cycle, plus a few literal expectations.
module tb_color_scan_controller;

    localparam int S    = 4;
    localparam int W    = 100;
    localparam int MINC = 8;
`ifdef COLOR_SCAN_CLEAR_EN
    localparam int NCH     = 4;
    localparam int LAT_LIT = 417;
`else
    localparam int NCH     = 3;
    localparam int LAT_LIT = 313;
`endif
    localparam int LAT = NCH * (S + W) + 1;

    logic clk = 1'b0;
    logic rst_n, start, continuous;
    logic sensor_a = 1'b0, sensor_b = 1'b0;
    logic [1:0]  scale_a, filter_a, scale_b, filter_b;
    logic [15:0] red_a, blue_a, green_a, clear_a;
    logic [3:0]  red_b, blue_b, green_b, clear_b;
    logic [2:0]  color_a, color_b;
    logic        rv_a, rv_b, busy_a, busy_b;

    always #5 clk = ~clk;

    color_scan_controller #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(16), .MIN_COUNT(MINC)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .sensor_freq(sensor_a),
        .scale(scale_a), .filter(filter_a), .red_cnt(red_a), .blue_cnt(blue_a), .green_cnt(green_a),
        .clear_cnt(clear_a), .color(color_a), .result_valid(rv_a), .busy(busy_a));

    color_scan_controller #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4), .MIN_COUNT(MINC)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .sensor_freq(sensor_b),
        .scale(scale_b), .filter(filter_b), .red_cnt(red_b), .blue_cnt(blue_b), .green_cnt(green_b),
        .clear_cnt(clear_b), .color(color_b), .result_valid(rv_b), .busy(busy_b));

    int total = 0;
    int bad = 0;
    longint cyc = 0;
    int per[4] = '{4, 4, 4, 4};
    int phase[4] = '{0, 0, 0, 0};
    logic [31:0] cfg_q[$];
    int opts[6] = '{4, 5, 10, 20, 25, 50};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int r, input int b, input int g, input int c);
        return {8'(c), 8'(g), 8'(b), 8'(r)};
    endfunction

    // Sensor: square wave per channel, period per[ch], high for the first half.
    function automatic int chan_of(input logic [1:0] f);
        case (f)
            2'b01:   return 1;
            2'b11:   return 2;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic wave(input int ch, input longint t);
        return ((t + longint'(phase[ch])) % longint'(per[ch])) < longint'(per[ch] / 2);
    endfunction

    always @(negedge clk) begin
        sensor_a = wave(chan_of(filter_a), cyc);
        sensor_b = wave(chan_of(filter_b), cyc);
    end

    function automatic logic [1:0] code_of(input int ch);
        case (ch)
            1:       return 2'b01;
            2:       return 2'b11;
            3:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] exp_color(input int r, input int b, input int g, input int c);
        int mx, winners;
        logic [2:0] col;
        mx = (r > b) ? r : b;
        mx = (mx > g) ? mx : g;
        winners = int'(r == mx) + int'(b == mx) + int'(g == mx);
        col = 3'b000;
        if (mx >= MINC && winners == 1)
            col = (r == mx) ? 3'b001 : (g == mx) ? 3'b100 : 3'b010;
        if (NCH == 4 && c < MINC)
            col = 3'b000;
        return col;
    endfunction

    // Scan-level model
    bit m_valid = 0, m_busy = 0;
    longint scan_start = 0, res_edge = 0;
    int pub_a[4] = '{0, 0, 0, 0};
    int pub_b[4] = '{0, 0, 0, 0};
    logic [2:0] pcol_a = 3'b000, pcol_b = 3'b000;
    int scans = 0;

    task automatic begin_scan();
        logic [31:0] cfg;
        m_busy = 1;
        scan_start = cyc;
        res_edge = cyc + LAT;
        if (cfg_q.size() > 0)
            cfg = cfg_q.pop_front();
        else
            cfg = pack(opts[$urandom_range(5, 0)], opts[$urandom_range(5, 0)],
                       opts[$urandom_range(5, 0)], opts[$urandom_range(5, 0)]);
        for (int c = 0; c < 4; c++) begin
            per[c] = int'(cfg[8*c +: 8]);
            phase[c] = $urandom_range(per[c] - 1, 0);
        end
    endtask

    always @(posedge clk) begin
        bit exp_rv;
        int ph;
        logic [1:0] exp_filter;
        cyc++;
        exp_rv = 0;
        if (!rst_n) begin
            m_valid = 1;
            m_busy = 0;
            for (int c = 0; c < 4; c++) begin
                pub_a[c] = 0;
                pub_b[c] = 0;
            end
            pcol_a = 3'b000;
            pcol_b = 3'b000;
        end else if (m_valid) begin
            if (m_busy) begin
                if (cyc == res_edge) begin
                    exp_rv = 1;
                    for (int c = 0; c < 4; c++) begin
                        pub_a[c] = (c < NCH) ? W / per[c] : 0;
                        pub_b[c] = (pub_a[c] > 15) ? 15 : pub_a[c];
                    end
                    pcol_a = exp_color(pub_a[0], pub_a[1], pub_a[2], pub_a[3]);
                    pcol_b = exp_color(pub_b[0], pub_b[1], pub_b[2], pub_b[3]);
                    if (continuous)
                        begin_scan();
                    else
                        m_busy = 0;
                end
            end else if (start) begin
                begin_scan();
            end
        end
        exp_filter = 2'b00;
        if (m_busy) begin
            ph = int'((cyc - scan_start) / (S + W));
            if (ph >= NCH) ph = NCH - 1;
            exp_filter = code_of(ph);
        end
        #1;
        if (m_valid) begin
            check("result_valid", rv_a, exp_rv);
            check("result_valid_b", rv_b, exp_rv);
            check("busy", busy_a, m_busy);
            check("scale", scale_a, m_busy ? 2'b10 : 2'b00);
            check("filter", filter_a, exp_filter);
            check("red_cnt", red_a, pub_a[0]);
            check("blue_cnt", blue_a, pub_a[1]);
            check("green_cnt", green_a, pub_a[2]);
            check("clear_cnt", clear_a, pub_a[3]);
            check("color", color_a, pcol_a);
            check("red_cnt_sat", red_b, pub_b[0]);
            check("blue_cnt_sat", blue_b, pub_b[1]);
            check("green_cnt_sat", green_b, pub_b[2]);
            check("color_sat", color_b, pcol_b);
            if (exp_rv) begin
                scans++;
                $display("scan %0d @%0d: red=%0d blue=%0d green=%0d clear=%0d color=%b | sat red=%0d color=%b",
                         scans, cyc, red_a, blue_a, green_a, clear_a, color_a, red_b, color_b);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (n < 2 * LAT + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (rv_a) break;
        end
        if (!rv_a) check("result_timeout", 0, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        cfg_q.push_back(pack(4, 10, 10, 10));
        cfg_q.push_back(pack(4, 10, 4, 10));
        cfg_q.push_back(pack(50, 50, 50, 50));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        pulse_start();
        wait_result(n);
        check("latency_literal", n, LAT_LIT);
        check("red_literal", red_a, 25);
        check("blue_literal", blue_a, 10);
        check("green_literal", green_a, 10);
        check("color_literal", color_a, 3'b001);
        check("red_sat_literal", red_b, 15);

        pulse_start();
        wait_result(n);
        check("tie_green_literal", green_a, 25);
        check("tie_color_literal", color_a, 3'b000);

        pulse_start();
        wait_result(n);
        check("lowcount_red_literal", red_a, 2);
        check("lowcount_color_literal", color_a, 3'b000);

        // Back-to-back scans, with a stray start mid-scan that must be ignored.
        continuous = 1'b1;
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        for (int k = 0; k < 3; k++) wait_result(n);
        continuous = 1'b0;
        wait_result(n);
        repeat (3) @(negedge clk);
        check("idle_after_continuous", busy_a, 0);

        // Reset during the blue window.
        pulse_start();
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        pulse_start();
        wait_result(n);
        check("latency_after_reset", n, LAT);

        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(5, 0)) @(negedge clk);
            pulse_start();
            wait_result(n);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
